// File: rtl/dmem_resp_pkg.sv
// dmem_responder shared types: FSM states, byte-mask constants, merge helper.
// Optional DMEM_RESP_ERR_EN build adds out-of-range error reporting.
package dmem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [3:0]  WEB_NONE = 4'b1111;
    localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;
    localparam int          CNT_W    = 4;

    // Bytes whose active-low enable is 0 take the new data.
    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_w,
        input logic [31:0] new_w,
        input logic [3:0]  web
    );
        logic [31:0] m;
        m = old_w;
        for (int b = 0; b < 4; b++) begin
            if (!web[b]) m[8*b +: 8] = new_w[8*b +: 8];
        end
        return m;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// SRAM-style request / ready-valid response bundle for dmem_responder.
// With DMEM_RESP_ERR_EN the address is a full 32-bit word address plus err.
interface dmem_responder_if #(
    parameter int AW = 14
);
    logic        req_cs;
    logic        req_oe;
    logic [3:0]  req_web;
`ifdef DMEM_RESP_ERR_EN
    logic [31:0] req_addr;
`else
    logic [AW-1:0] req_addr;
`endif
    logic [31:0] req_wdata;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
`ifdef DMEM_RESP_ERR_EN
    logic        err;

    modport master (
        output req_cs, req_oe, req_web, req_addr, req_wdata,
        input  ready, rvalid, rdata, err
    );

    modport slave (
        input  req_cs, req_oe, req_web, req_addr, req_wdata,
        output ready, rvalid, rdata, err
    );
`else
    modport master (
        output req_cs, req_oe, req_web, req_addr, req_wdata,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  req_cs, req_oe, req_web, req_addr, req_wdata,
        output ready, rvalid, rdata
    );
`endif

endinterface

// File: rtl/dmem_array.sv
// Word array with per-byte write mask and a registered read port.
// A combined read/write returns the post-merge word.
module dmem_array
    import dmem_resp_pkg::*;
#(
    parameter int DEPTH = 16384,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          commit_i,
    input  logic          re_i,
    input  logic [3:0]    web_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] merged;
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;

    assign merged = merge_bytes(mem_q[addr_i], wdata_i, web_i);

    // Storage is intentionally left without reset.
    always_ff @(posedge clk) begin
        if (commit_i && (web_i != WEB_NONE)) begin
            mem_q[addr_i] <= merged;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (commit_i && re_i) rdata_d = merged;
    end

    always_ff @(posedge clk) begin
        if (!rst) rdata_q <= '0;
        else      rdata_q <= rdata_d;
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder with programmable wait states (IDLE/WAIT/RESP FSM).
// DMEM_RESP_ERR_EN enables out-of-range detection and the err output.
module dmem_responder
    import dmem_resp_pkg::*;
#(
    parameter int DEPTH       = 16384,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    dmem_responder_if.slave   bus
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        web_q, web_d;
    logic              oe_q, oe_d;
    logic              oob_q, oob_d;
    logic              commit;
    logic              commit_en;

    logic [AW-1:0]     req_addr;
    logic              req_oob;
    logic [AW-1:0]     c_addr;
    logic [31:0]       c_wdata;
    logic [3:0]        c_web;
    logic              c_oe;
    logic              c_oob;
    logic [31:0]       arr_rdata;

`ifdef DMEM_RESP_ERR_EN
    logic [31:0]       req_addr_full;
    logic              err_q, err_d;
    logic              errdat_q, errdat_d;

    assign req_addr_full = bus.req_addr;
    assign req_oob       = (req_addr_full >= 32'(DEPTH));
    assign req_addr      = req_addr_full[AW-1:0];
`else
    assign req_oob       = 1'b0;
    assign req_addr      = bus.req_addr;
`endif

    // Zero wait states commit straight from the live request.
    always_comb begin
        c_addr  = addr_q;
        c_wdata = wdata_q;
        c_web   = web_q;
        c_oe    = oe_q;
        c_oob   = oob_q;
        if (state_q == IDLE) begin
            c_addr  = req_addr;
            c_wdata = bus.req_wdata;
            c_web   = bus.req_web;
            c_oe    = bus.req_oe;
            c_oob   = req_oob;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        web_d   = web_q;
        oe_d    = oe_q;
        oob_d   = oob_q;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.req_cs) begin
                    addr_d  = req_addr;
                    wdata_d = bus.req_wdata;
                    web_d   = bus.req_web;
                    oe_d    = bus.req_oe;
                    oob_d   = req_oob;
                    cnt_d   = CNT_LOAD;
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A reset on the commit edge discards the pending write.
    assign commit_en = commit & rst;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            web_q   <= WEB_NONE;
            oe_q    <= 1'b0;
            oob_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            web_q   <= web_d;
            oe_q    <= oe_d;
            oob_q   <= oob_d;
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .commit_i (commit_en & ~c_oob),
        .re_i     (c_oe),
        .web_i    (c_web),
        .addr_i   (c_addr),
        .wdata_i  (c_wdata),
        .rdata_o  (arr_rdata)
    );

    assign bus.ready  = (state_q == IDLE);
    assign bus.rvalid = (state_q == RESP);

`ifdef DMEM_RESP_ERR_EN
    // errdat_q keeps the error pattern visible until a real read replaces it.
    always_comb begin
        err_d    = err_q;
        errdat_d = errdat_q;
        if (commit_en) begin
            err_d = c_oob;
            if (c_oob)     errdat_d = 1'b1;
            else if (c_oe) errdat_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_q    <= 1'b0;
            errdat_q <= 1'b0;
        end else begin
            err_q    <= err_d;
            errdat_q <= errdat_d;
        end
    end

    assign bus.rdata = errdat_q ? ERR_DATA : arr_rdata;
    assign bus.err   = bus.rvalid & err_q;
`else
    assign bus.rdata = arr_rdata;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench for dmem_responder (WAIT_CYCLES=2 and 0).
// Define DMEM_RESP_ERR_EN to also exercise the out-of-range path.
module tb_dmem_responder;

    localparam int DEPTH = 16384;
    localparam int AW    = $clog2(DEPTH);
`ifdef DMEM_RESP_ERR_EN
    localparam int PAW   = 32;
`else
    localparam int PAW   = AW;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    dmem_responder_if #(.AW(AW)) bus  ();
    dmem_responder_if #(.AW(AW)) bus0 ();

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] mem_m [int];
    logic [31:0] rd_m  [2];
    logic [31:0] sb_data [$];
    logic        sb_err  [$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic f_rvalid(input bit s);
        return s ? bus0.rvalid : bus.rvalid;
    endfunction

    function automatic logic f_ready(input bit s);
        return s ? bus0.ready : bus.ready;
    endfunction

    function automatic logic [31:0] f_rdata(input bit s);
        return s ? bus0.rdata : bus.rdata;
    endfunction

    function automatic logic f_err(input bit s);
`ifdef DMEM_RESP_ERR_EN
        return s ? bus0.err : bus.err;
`else
        return 1'b0 & s;
`endif
    endfunction

    task automatic drive(input bit s, input logic cs, input logic oe,
                         input logic [3:0] web, input int addr,
                         input logic [31:0] wd);
        if (s) begin
            bus0.req_cs    = cs;
            bus0.req_oe    = oe;
            bus0.req_web   = web;
            bus0.req_addr  = PAW'(addr);
            bus0.req_wdata = wd;
        end else begin
            bus.req_cs     = cs;
            bus.req_oe     = oe;
            bus.req_web    = web;
            bus.req_addr   = PAW'(addr);
            bus.req_wdata  = wd;
        end
    endtask

    // Model the expected result, issue one request, check its response.
    task automatic txn(input bit s, input logic oe, input logic [3:0] web,
                       input int addr, input logic [31:0] wd, input int wc);
        logic [31:0] cur, nw, exp_d;
        logic        exp_e;
        int          key, k;
        bit          seen, oob;
        oob = 1'b0;
`ifdef DMEM_RESP_ERR_EN
        oob = (addr >= DEPTH);
`endif
        exp_e = oob;
        if (oob) begin
            rd_m[s] = 32'hDEADBEEF;
        end else begin
            key = (int'(s) << 20) | (addr % DEPTH);
            cur = mem_m.exists(key) ? mem_m[key] : 32'h0;
            nw  = cur;
            if (!web[0]) nw[7:0]   = wd[7:0];
            if (!web[1]) nw[15:8]  = wd[15:8];
            if (!web[2]) nw[23:16] = wd[23:16];
            if (!web[3]) nw[31:24] = wd[31:24];
            if (web != 4'hF) mem_m[key] = nw;
            if (oe) rd_m[s] = nw;
        end
        exp_d = rd_m[s];
        @(negedge clk);
        drive(s, 1'b1, oe, web, addr, wd);
        sb_data.push_back(exp_d);
        sb_err.push_back(exp_e);
        check("ready_before_req", 32'(f_ready(s)), 32'd1);
        @(posedge clk);
        @(negedge clk);
        drive(s, 1'b0, 1'b0, 4'hF, 0, 32'h0);
        k    = 1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (f_rvalid(s)) seen = 1'b1;
            else begin
                k++;
                @(negedge clk);
            end
        end
        exp_d = sb_data.pop_front();
        exp_e = sb_err.pop_front();
        check("rvalid_seen", 32'(seen), 32'd1);
        if (seen) begin
            check("latency", 32'(k), 32'(wc + 1));
            check("rdata", f_rdata(s), exp_d);
            check("err", 32'(f_err(s)), 32'(exp_e));
            check("ready_in_resp", 32'(f_ready(s)), 32'd0);
            @(negedge clk);
            check("rvalid_pulse_end", 32'(f_rvalid(s)), 32'd0);
            check("ready_after_resp", 32'(f_ready(s)), 32'd1);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        rd_m[0] = 32'h0;
        rd_m[1] = 32'h0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int p1, p2, pulses;
        bit idle;
        drive(0, 1'b0, 1'b0, 4'hF, 0, 32'h0);
        drive(1, 1'b0, 1'b0, 4'hF, 0, 32'h0);
        do_reset();
        @(negedge clk);
        check("rst_ready",   32'(bus.ready),   32'd1);
        check("rst_rvalid",  32'(bus.rvalid),  32'd0);
        check("rst_rdata",   bus.rdata,        32'h0);
        check("rst_ready0",  32'(bus0.ready),  32'd1);
        check("rst_rvalid0", 32'(bus0.rvalid), 32'd0);
        check("rst_rdata0",  bus0.rdata,       32'h0);
`ifdef DMEM_RESP_ERR_EN
        check("rst_err",     32'(bus.err),     32'd0);
`endif

        // Write then read, two wait states.
        txn(0, 1'b0, 4'b0000, 5, 32'h12345678, 2);
        txn(0, 1'b1, 4'b1111, 5, 32'h0, 2);

        // Byte merge.
        txn(0, 1'b0, 4'b0000, 9, 32'hAABBCCDD, 2);
        txn(0, 1'b0, 4'b1010, 9, 32'h11223344, 2);
        txn(0, 1'b1, 4'b1111, 9, 32'h0, 2);

        // Reset during WAIT discards the write.
        txn(0, 1'b0, 4'b0000, 3, 32'h00000001, 2);
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 4'b0000, 3, 32'hFFFFFFFF);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 4'hF, 0, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        rd_m[0] = 32'h0;
        rd_m[1] = 32'h0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.rvalid) pulses++;
        end
        check("abort_no_rvalid", 32'(pulses), 32'd0);
        check("abort_ready", 32'(bus.ready), 32'd1);
        check("abort_rdata", bus.rdata, 32'h0);
        txn(0, 1'b1, 4'b1111, 3, 32'h0, 2);

        // Null access keeps rdata; combined access returns merged word.
        txn(0, 1'b1, 4'b1111, 5, 32'h0, 2);
        txn(0, 1'b0, 4'b1111, 9, 32'hFFFFFFFF, 2);
        txn(0, 1'b0, 4'b0000, 7, 32'h00000000, 2);
        txn(0, 1'b1, 4'b1110, 7, 32'h000000FF, 2);
        txn(0, 1'b1, 4'b1111, 7, 32'h0, 2);

        // cs held high: back-to-back accepts every WAIT_CYCLES+2 cycles.
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 4'hF, 5, 32'h0);
        p1 = -1;
        p2 = -1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (bus.rvalid) begin
                check("b2b_rdata", bus.rdata, 32'h12345678);
                if (p1 < 0) p1 = i;
                else if (p2 < 0) p2 = i;
            end
        end
        drive(0, 1'b0, 1'b0, 4'hF, 0, 32'h0);
        check("b2b_gap", 32'(p2 - p1), 32'd4);
        idle = 1'b0;
        for (int i = 0; i < 10 && !idle; i++) begin
            @(negedge clk);
            if (bus.ready && !bus.rvalid) idle = 1'b1;
        end
        check("b2b_drain", 32'(idle), 32'd1);
        rd_m[0] = 32'h12345678;

        // Zero wait states.
        txn(1, 1'b0, 4'b0000, 2, 32'hCAFEF00D, 0);
        txn(1, 1'b1, 4'b1111, 2, 32'h0, 0);

`ifdef DMEM_RESP_ERR_EN
        txn(0, 1'b1, 4'b1111, DEPTH + 1, 32'h0, 2);
        txn(0, 1'b1, 4'b1111, 5, 32'h0, 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
